vdp_sprite_raster_collision_scan: RTL and testbench
===================================================

// Module: vdp_sprite_raster_collision_scan
// PURPOSE
// - Per-line sprite Y-intersection scanner for the VDP sprite engine.
// - On each line restart it sequentially reads all 256 sprite Y attributes and tests them against an upcoming raster line.
// - It writes one hit-list entry per intersecting sprite, then a terminator entry.
// - The sprite renderer consumes the list on the following line (double-buffered hit list).
// PARAMETERS
// - Y_OFFSET  2  lines ahead of raster_y that the list is built for; target_y = (raster_y + Y_OFFSET) mod 512
// PORTS
// - clk                 in   1  system clock; one clock domain
// - reset               in   1  synchronous, active-high
// - restart             in   1  begin a new scan (pulse once per line)
// - raster_y            in   9  current raster line
// - sprite_test_id      out  8  Y-attribute RAM read address (sprite under test)
// - sprite_y            in   9  sprite Y; RAM data, valid 1 cycle after sprite_test_id
// - sprite_height       in   5  sprite height, 8 or 16 (any 0..16 legal); same timing as sprite_y
// - flip_y              in   1  vertical flip; same timing as sprite_y
// - width_select_in     in   1  width select (8/16); same timing as sprite_y
// - hit_list_write_en   out  1  write strobe for hit-list entry
// - hit_list_index      out  8  hit-list write address
// - sprite_id           out  8  ID of intersecting sprite
// - sprite_y_intersect  out  4  row within sprite to fetch (flip applied)
// - width_select_out    out  1  copy of width_select_in for the hit
// - finished            out  1  high on the terminator write and while idle after a completed scan
// BEHAVIOUR
// - States:
//   - IDLE -> SCAN on restart.
//   - SCAN -> TERM after sprite 255 has been tested.
//   - TERM -> DONE (1 cycle).
//   - DONE holds until restart.
// - restart has priority in every state, including mid-scan:
//   - clears the ID counter and hit count;
//   - the aborted scan writes no terminator.
// - Restart timing:
//   - The cycle after restart: sprite_test_id = 0.
//   - It then increments once per cycle through 255.
//   - sprite_test_id holds at 0 while idle.
// - Hit test, on the data for sprite n:
//   - delta = (target_y - sprite_y) mod 512, 9-bit wrap.
//   - Hit iff delta < sprite_height.
//   - Sprites straddling line 511 therefore wrap to line 0.
//   - Height 0 never hits.
// - Row: sprite_y_intersect = flip_y ? (sprite_height - 1 - delta) : delta, low 4 bits.
// - Hit write (registered, 2 cycles after sprite_test_id == n):
//   - hit_list_write_en = 1, hit_list_index = hit count, sprite_id = n.
//   - The hit count is then incremented.
// - Entries are written in ascending sprite ID order. Non-hits produce no write.
// - Capacity is 255 hits: once the count reaches 255, further hits are dropped so the terminator always fits.
// - Terminator write:
//   - Issued the cycle after the last possible hit write.
//   - write_en = 1, finished = 1, index = hit count; sprite_id, intersect and width outputs = 0.
// - finished:
//   - Stays 1 in DONE.
//   - Goes to 0 on restart/SCAN.
// - Scan length is 259 cycles from restart to terminator.
// - reset (synchronous):
//   - State IDLE; sprite_test_id = 0, hit count = 0.
//   - hit_list_write_en = 0, finished = 0.
//   - All data outputs 0.
//   - Reset mid-scan aborts without a terminator.
// TESTING
// - Only sprite 5 intersects (y=100, h=8; others y=300), raster_y=98 -> write idx0 id5 row0, then terminator idx1, finished=1.
// - Sprite 5 y=100, h=16, flip_y=1, raster_y=101 (delta 3) -> row 12; width_select_in=1 appears as width_select_out=1.
// - Sprite y=510, h=16, raster_y=2 (target 4, delta 6) -> hit, row 6; y=200, raster_y=2 -> no write.
// - All 256 sprites hit -> entries idx0..254 = ids 0..254, id 255 dropped, terminator at idx 255.
// - restart asserted 100 cycles into a scan -> sprite_test_id returns to 0, index restarts at 0, only one terminator total.
// - reset asserted mid-scan -> write_en low next cycle, no further writes until restart; cycle count restart->terminator = 259.

Source files
------------

// File: rtl/vdp_sprite_raster_collision_scan.sv
// ----------------------------------------------------------------------------
// vdp_sprite_raster_collision_scan
//
// Per-line sprite Y-intersection scanner. On every restart it walks all 256
// sprite Y attributes (one per clock), tests each against the raster line
// Y_OFFSET lines ahead of raster_y_i, and writes one hit-list entry per
// intersecting sprite followed by a terminator entry.
//
// Ports
//   clk_i                 system clock
//   reset_i               synchronous, active-high reset
//   restart_i             start a new scan (one pulse per line)
//   raster_y_i     [8:0]  current raster line
//   sprite_test_id_o [7:0] Y-attribute RAM read address
//   sprite_y_i     [8:0]  sprite Y, valid one cycle after the address
//   sprite_height_i[4:0]  sprite height 0..16, same timing as sprite_y_i
//   flip_y_i              vertical flip, same timing as sprite_y_i
//   width_select_i        width select, same timing as sprite_y_i
//   hit_list_write_en_o   hit-list write strobe
//   hit_list_index_o [7:0] hit-list write address
//   sprite_id_o    [7:0]  ID of the intersecting sprite
//   sprite_y_intersect_o [3:0] sprite row to fetch (flip applied)
//   width_select_o        width select of the hit sprite
//   finished_o            high on the terminator write and while done
// ----------------------------------------------------------------------------
module vdp_sprite_raster_collision_scan #(
    parameter int unsigned Y_OFFSET = 2
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       restart_i,
    input  logic [8:0] raster_y_i,
    output logic [7:0] sprite_test_id_o,
    input  logic [8:0] sprite_y_i,
    input  logic [4:0] sprite_height_i,
    input  logic       flip_y_i,
    input  logic       width_select_i,
    output logic       hit_list_write_en_o,
    output logic [7:0] hit_list_index_o,
    output logic [7:0] sprite_id_o,
    output logic [3:0] sprite_y_intersect_o,
    output logic       width_select_o,
    output logic       finished_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_TERM = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] id_q, id_d;          // RAM address currently presented
    logic       issue_q, issue_d;    // id_q is a live read this cycle
    logic       s1_valid_q, s1_valid_d; // RAM data on the inputs is live
    logic [7:0] s1_id_q, s1_id_d;    // sprite whose data is on the inputs
    logic [7:0] cnt_q, cnt_d;        // hits written so far
    logic       we_q, we_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] sid_q, sid_d;
    logic [3:0] row_q, row_d;
    logic       wsel_q, wsel_d;
    logic       fin_q, fin_d;

    logic [8:0] target_s;
    logic [8:0] delta_s;
    logic [8:0] flip_row_s;
    logic       hit_s;
    logic [3:0] row_s;

    // Hit test on the RAM data returned for sprite s1_id_q; all 9-bit wrap arithmetic.
    always_comb begin
        target_s   = raster_y_i + 9'(Y_OFFSET);
        delta_s    = target_s - sprite_y_i;
        hit_s      = (delta_s < {4'd0, sprite_height_i});
        flip_row_s = {4'd0, sprite_height_i} - 9'd1 - delta_s;
        if (flip_y_i) begin
            row_s = flip_row_s[3:0];
        end else begin
            row_s = delta_s[3:0];
        end
    end

    // Next-state and registered-output logic; restart overrides every state.
    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        issue_d    = issue_q;
        s1_valid_d = 1'b0;
        s1_id_d    = 8'd0;
        cnt_d      = cnt_q;
        we_d       = 1'b0;
        idx_d      = 8'd0;
        sid_d      = 8'd0;
        row_d      = 4'd0;
        wsel_d     = 1'b0;
        fin_d      = fin_q;
        if (restart_i) begin
            state_d = S_SCAN;
            id_d    = 8'd0;
            issue_d = 1'b1;
            cnt_d   = 8'd0;
            fin_d   = 1'b0;
        end else begin
            case (state_q)
                S_SCAN: begin
                    s1_valid_d = issue_q;
                    s1_id_d    = id_q;
                    if (issue_q) begin
                        if (id_q == 8'd255) begin
                            issue_d = 1'b0;
                            id_d    = 8'd0;
                        end else begin
                            id_d = id_q + 8'd1;
                        end
                    end else begin
                        id_d = 8'd0;
                    end
                    if (s1_valid_q) begin
                        // A count of 255 reserves the last slot for the terminator.
                        if (hit_s && (cnt_q != 8'd255)) begin
                            we_d   = 1'b1;
                            idx_d  = cnt_q;
                            sid_d  = s1_id_q;
                            row_d  = row_s;
                            wsel_d = width_select_i;
                            cnt_d  = cnt_q + 8'd1;
                        end else begin
                            cnt_d = cnt_q;
                        end
                        if (s1_id_q == 8'd255) begin
                            state_d = S_TERM;
                        end else begin
                            state_d = S_SCAN;
                        end
                    end else begin
                        state_d = S_SCAN;
                    end
                end
                S_TERM: begin
                    we_d    = 1'b1;
                    idx_d   = cnt_q;
                    fin_d   = 1'b1;
                    state_d = S_DONE;
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    issue_d = 1'b0;
                    id_d    = 8'd0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            id_q       <= 8'd0;
            issue_q    <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_id_q    <= 8'd0;
            cnt_q      <= 8'd0;
            we_q       <= 1'b0;
            idx_q      <= 8'd0;
            sid_q      <= 8'd0;
            row_q      <= 4'd0;
            wsel_q     <= 1'b0;
            fin_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            issue_q    <= issue_d;
            s1_valid_q <= s1_valid_d;
            s1_id_q    <= s1_id_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            idx_q      <= idx_d;
            sid_q      <= sid_d;
            row_q      <= row_d;
            wsel_q     <= wsel_d;
            fin_q      <= fin_d;
        end
    end

    assign sprite_test_id_o     = id_q;
    assign hit_list_write_en_o  = we_q;
    assign hit_list_index_o     = idx_q;
    assign sprite_id_o          = sid_q;
    assign sprite_y_intersect_o = row_q;
    assign width_select_o       = wsel_q;
    assign finished_o           = fin_q;

endmodule

// File: tb/tb_vdp_sprite_raster_collision_scan.sv
module tb_vdp_sprite_raster_collision_scan;

    logic       clk = 1'b0;
    logic       reset;
    logic       restart;
    logic [8:0] raster_y;
    logic [7:0] sprite_test_id;
    logic [8:0] sprite_y;
    logic [4:0] sprite_height;
    logic       flip_y;
    logic       width_sel_in;
    logic       we;
    logic [7:0] hl_index;
    logic [7:0] sprite_id;
    logic [3:0] row;
    logic       width_sel_out;
    logic       finished;

    vdp_sprite_raster_collision_scan #(.Y_OFFSET(2)) dut (
        .clk_i                (clk),
        .reset_i              (reset),
        .restart_i            (restart),
        .raster_y_i           (raster_y),
        .sprite_test_id_o     (sprite_test_id),
        .sprite_y_i           (sprite_y),
        .sprite_height_i      (sprite_height),
        .flip_y_i             (flip_y),
        .width_select_i       (width_sel_in),
        .hit_list_write_en_o  (we),
        .hit_list_index_o     (hl_index),
        .sprite_id_o          (sprite_id),
        .sprite_y_intersect_o (row),
        .width_select_o       (width_sel_out),
        .finished_o           (finished)
    );

    always #5 clk = ~clk;

    // Sprite attribute RAM model: one-cycle read latency.
    logic [8:0] ram_y [256];
    logic [4:0] ram_h [256];
    logic       ram_f [256];
    logic       ram_w [256];

    always @(posedge clk) begin
        sprite_y      <= ram_y[sprite_test_id];
        sprite_height <= ram_h[sprite_test_id];
        flip_y        <= ram_f[sprite_test_id];
        width_sel_in  <= ram_w[sprite_test_id];
    end

    // Captured writes
    int wr_idx [300];
    int wr_id  [300];
    int wr_row [300];
    int wr_w   [300];
    int wr_fin [300];
    int n_wr;
    int n_term;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        string      name;
        logic [8:0] ry;
        int         spr;
        logic [8:0] sy;
        logic [4:0] sh;
        logic       sf;
        logic       sw;
        logic       exp_hit;
        int         exp_row;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic fill_bg();
        for (int i = 0; i < 256; i++) begin
            ram_y[i] = 9'd300;
            ram_h[i] = 5'd8;
            ram_f[i] = 1'b0;
            ram_w[i] = 1'b0;
        end
    endtask

    // Sample outputs (called on the falling edge) and log any write.
    task automatic record();
        if (we === 1'b1) begin
            if (n_wr < 300) begin
                wr_idx[n_wr] = int'(hl_index);
                wr_id[n_wr]  = int'(sprite_id);
                wr_row[n_wr] = int'(row);
                wr_w[n_wr]   = int'(width_sel_out);
                wr_fin[n_wr] = int'(finished);
            end
            n_wr++;
            if (finished === 1'b1) n_term++;
        end
    endtask

    // Pulse restart and collect writes until the terminator or a cycle budget.
    // term_cyc = clock edges from the one sampling restart to the one producing the terminator.
    task automatic run_scan(output int term_cyc);
        n_wr = 0;
        n_term = 0;
        term_cyc = -1;
        @(negedge clk);
        restart = 1'b1;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            restart = 1'b0;
            record();
            if (we === 1'b1 && finished === 1'b1) begin
                term_cyc = c;
                break;
            end
        end
    endtask

    initial begin
        int tc;
        int bad;
        int last;

        vecs[0] = '{"basic_hit",     9'd98,  5,   9'd100, 5'd8,  1'b0, 1'b0, 1'b1, 0};
        vecs[1] = '{"flip_h16",      9'd101, 5,   9'd100, 5'd16, 1'b1, 1'b1, 1'b1, 12};
        vecs[2] = '{"wrap_511",      9'd2,   7,   9'd510, 5'd16, 1'b0, 1'b0, 1'b1, 6};
        vecs[3] = '{"no_hit_far",    9'd2,   7,   9'd200, 5'd16, 1'b0, 1'b0, 1'b0, 0};
        vecs[4] = '{"height_zero",   9'd98,  9,   9'd100, 5'd0,  1'b0, 1'b0, 1'b0, 0};
        vecs[5] = '{"last_row",      9'd105, 200, 9'd100, 5'd8,  1'b0, 1'b1, 1'b1, 7};
        vecs[6] = '{"past_last_row", 9'd106, 200, 9'd100, 5'd8,  1'b0, 1'b0, 1'b0, 0};
        vecs[7] = '{"target_wrap",   9'd510, 255, 9'd0,   5'd8,  1'b1, 1'b0, 1'b1, 7};
        vecs[8] = '{"both_wrap",     9'd510, 0,   9'd511, 5'd4,  1'b0, 1'b0, 1'b1, 1};
        vecs[9] = '{"flip_h13",      9'd98,  77,  9'd100, 5'd13, 1'b1, 1'b1, 1'b1, 12};

        reset = 1'b1;
        restart = 1'b0;
        raster_y = 9'd0;
        fill_bg();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        chk("reset_we", int'(we), 0);
        chk("reset_finished", int'(finished), 0);
        chk("reset_test_id", int'(sprite_test_id), 0);
        chk("reset_index", int'(hl_index), 0);
        repeat (3) @(negedge clk);
        chk("idle_test_id", int'(sprite_test_id), 0);

        // Table-driven single-sprite vectors
        for (int v = 0; v < 10; v++) begin
            fill_bg();
            ram_y[vecs[v].spr] = vecs[v].sy;
            ram_h[vecs[v].spr] = vecs[v].sh;
            ram_f[vecs[v].spr] = vecs[v].sf;
            ram_w[vecs[v].spr] = vecs[v].sw;
            raster_y = vecs[v].ry;
            run_scan(tc);
            chk({vecs[v].name, "_term_cycles"}, tc, 259);
            chk({vecs[v].name, "_nwrites"}, n_wr, vecs[v].exp_hit ? 2 : 1);
            if (vecs[v].exp_hit) begin
                chk({vecs[v].name, "_hit_idx"}, wr_idx[0], 0);
                chk({vecs[v].name, "_hit_id"}, wr_id[0], vecs[v].spr);
                chk({vecs[v].name, "_hit_row"}, wr_row[0], vecs[v].exp_row);
                chk({vecs[v].name, "_hit_wsel"}, wr_w[0], int'(vecs[v].sw));
                chk({vecs[v].name, "_hit_fin"}, wr_fin[0], 0);
            end
            last = (n_wr > 0 && n_wr <= 300) ? n_wr - 1 : 0;
            chk({vecs[v].name, "_term_idx"}, wr_idx[last], vecs[v].exp_hit ? 1 : 0);
            chk({vecs[v].name, "_term_id"}, wr_id[last], 0);
            chk({vecs[v].name, "_term_row"}, wr_row[last], 0);
            chk({vecs[v].name, "_term_wsel"}, wr_w[last], 0);
            repeat (2) @(negedge clk);
            chk({vecs[v].name, "_done_finished"}, int'(finished), 1);
            chk({vecs[v].name, "_done_we"}, int'(we), 0);
            chk({vecs[v].name, "_done_test_id"}, int'(sprite_test_id), 0);
        end

        // All 256 sprites hit: id 255 dropped, terminator at index 255
        fill_bg();
        for (int i = 0; i < 256; i++) ram_y[i] = 9'd100;
        raster_y = 9'd98;
        run_scan(tc);
        chk("allhit_nwrites", n_wr, 256);
        bad = 0;
        for (int i = 0; i < 255; i++) begin
            if (wr_idx[i] != i || wr_id[i] != i || wr_fin[i] != 0) bad++;
        end
        chk("allhit_bad_entries", bad, 0);
        chk("allhit_term_idx", wr_idx[255], 255);
        chk("allhit_term_fin", wr_fin[255], 1);
        chk("allhit_term_id", wr_id[255], 0);
        chk("allhit_term_cycles", tc, 259);

        // Restart 100 cycles into a scan
        fill_bg();
        ram_y[5] = 9'd100;
        raster_y = 9'd98;
        n_wr = 0;
        n_term = 0;
        @(negedge clk);
        restart = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            restart = 1'b0;
            record();
        end
        chk("midrestart_pre_id", int'(sprite_test_id), 99);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk("midrestart_test_id", int'(sprite_test_id), 0);
        record();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            record();
        end
        chk("midrestart_nwrites", n_wr, 3);
        chk("midrestart_nterm", n_term, 1);
        chk("midrestart_rehit_idx", wr_idx[1], 0);
        chk("midrestart_rehit_id", wr_id[1], 5);
        chk("midrestart_term_idx", wr_idx[2], 1);

        // Reset mid-scan, then a clean scan
        fill_bg();
        ram_y[200] = 9'd100;
        raster_y = 9'd98;
        n_wr = 0;
        n_term = 0;
        @(negedge clk);
        restart = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            restart = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midreset_we", int'(we), 0);
        chk("midreset_test_id", int'(sprite_test_id), 0);
        chk("midreset_finished", int'(finished), 0);
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            record();
        end
        chk("midreset_no_writes", n_wr, 0);
        run_scan(tc);
        chk("postreset_term_cycles", tc, 259);
        chk("postreset_hit_id", wr_id[0], 200);
        chk("postreset_nwrites", n_wr, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
